// File: rtl/conversor_paralelo_serie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conversor_paralelo_serie_pkg
// Purpose  : Shared definitions for the SMSL serial-link transmitter.
//            - SMSL_WIDTH : default data word width
//            - estado_t   : FSM state encodings (IDLE/SHIFT/PARITY/DONE)
// Revision : 1.0 - initial release
// ============================================================================
package conversor_paralelo_serie_pkg;

    // Default word width for the link.
    localparam int SMSL_WIDTH = 8;

    // The encodings are fixed because the receiving side and debug tools
    // decode these state values directly.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } estado_t;

endpackage : conversor_paralelo_serie_pkg
`default_nettype wire

// File: rtl/conversor_paralelo_serie_contador.sv
`default_nettype none
// ============================================================================
// Module   : contador_bits
// Purpose  : CNT_W-bit bit counter for the serialiser. Synchronous clear has
//            priority over enable. tc flags the terminal count WIDTH-1.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset (count = 0)
//            clr  - synchronous clear
//            en   - count enable
//            tc   - high while count == WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module contador_bits #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] C_ULTIMO = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cuenta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cuenta <= '0;
        end else if (clr) begin
            r_cuenta <= '0;
        end else if (en) begin
            r_cuenta <= r_cuenta + CNT_W'(1);
        end
    end

    assign tc = (r_cuenta == C_ULTIMO);

endmodule : contador_bits
`default_nettype wire

// File: rtl/conversor_paralelo_serie.sv
`default_nettype none
// ============================================================================
// Module   : conversor_paralelo_serie
// Purpose  : Parallel-to-serial transmitter of the SMSL link. Accepts a word
//            through a ready/valid handshake (listo/cargar) and shifts it out
//            MSB first, one bit per clock, with bit_control high on every
//            data-bit cycle as the receiver's shift enable. fin pulses for
//            one cycle after the last bit. All outputs are registered.
// Config   : SMSL_PARITY_EN - when defined, an even-parity bit follows the
//            data bits (bit_control stays high for it).
// Ports    : clk         - system clock, rising edge
//            rst         - asynchronous active-high reset
//            dato_in     - parallel word, sampled on an accepted load
//            cargar      - load request (valid)
//            listo       - idle / ready to accept
//            dato        - serial data, MSB first
//            bit_control - high while dato carries a link bit
//            fin         - one-cycle end-of-word pulse
// Revision : 1.0 - initial release
// ============================================================================
module conversor_paralelo_serie
    import conversor_paralelo_serie_pkg::*;
#(
    parameter int WIDTH = SMSL_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dato_in,
    input  logic             cargar,
    output logic             listo,
    output logic             dato,
    output logic             bit_control,
    output logic             fin
);

    estado_t          r_estado;
    estado_t          w_siguiente;
    logic [WIDTH-1:0] r_shreg;
    logic             w_acepta;
    logic             w_dato_n;
    logic             w_clr;
    logic             w_en;
    logic             w_tc;
`ifdef SMSL_PARITY_EN
    logic             r_paridad;
`endif

    contador_bits #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_contador (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_en),
        .tc  (w_tc)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_siguiente;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counter control and next serial bit. The outputs are
    // registered, so everything here describes the cycle after the edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_siguiente = r_estado;
        w_acepta    = 1'b0;
        w_dato_n    = 1'b0;
        w_clr       = 1'b1;
        w_en        = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                if (cargar) begin
                    w_acepta    = 1'b1;
                    w_siguiente = ST_SHIFT;
                    w_dato_n    = dato_in[WIDTH-1];
                end
            end
            ST_SHIFT: begin
                // The terminal count ends the word; the counter never wraps.
                if (w_tc) begin
`ifdef SMSL_PARITY_EN
                    w_siguiente = ST_PARITY;
                    w_dato_n    = r_paridad;
`else
                    w_siguiente = ST_DONE;
`endif
                end else begin
                    w_clr    = 1'b0;
                    w_en     = 1'b1;
                    w_dato_n = r_shreg[WIDTH-1];
                end
            end
            ST_PARITY: begin
                w_siguiente = ST_DONE;
            end
            ST_DONE: begin
                w_siguiente = ST_IDLE;
            end
            default: begin
                w_siguiente = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register. The MSB goes straight to dato on acceptance, so the
    // register holds the remaining bits with the next one at the top.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_acepta) begin
            r_shreg <= {dato_in[WIDTH-2:0], 1'b0};
        end else if (r_estado == ST_SHIFT) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SMSL_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paridad <= 1'b0;
        end else if (w_acepta) begin
            r_paridad <= ^dato_in;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            listo       <= 1'b1;
            dato        <= 1'b0;
            bit_control <= 1'b0;
            fin         <= 1'b0;
        end else begin
            listo       <= (w_siguiente == ST_IDLE);
            dato        <= w_dato_n;
            bit_control <= (w_siguiente == ST_SHIFT) || (w_siguiente == ST_PARITY);
            fin         <= (w_siguiente == ST_DONE);
        end
    end

endmodule : conversor_paralelo_serie
`default_nettype wire
